// File: rtl/ca_ctrl_pkg.sv
// Shared types and defaults for the cellular-automaton run controller.
package ca_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int                    H_DISPLAY_DEF  = 640;
  localparam int                    V_DISPLAY_DEF  = 480;
  localparam int                    VRAM_SIZE      = H_DISPLAY_DEF * V_DISPLAY_DEF;
  localparam int                    AVN_DW_DEF     = 16;
  localparam logic [AVN_DW_DEF-1:0] CLEAR_DATA_DEF = '1;
  localparam logic [7:0]            RULE_INIT_DEF  = 8'd30;

  // Width of a counter whose largest value is terminal-1 (never narrower than 1 bit).
  function automatic int cnt_w(input int terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/ca_vram_clear.sv
// Frame fill engine: writes FILL to addresses 0..DEPTH-1 over an Avalon write master.
module ca_vram_clear
  import ca_ctrl_pkg::*;
#(
  parameter int            AW    = 19,
  parameter int            DW    = AVN_DW_DEF,
  parameter int            DEPTH = VRAM_SIZE,
  parameter logic [DW-1:0] FILL  = CLEAR_DATA_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          waitrequest,
  output logic          write,
  output logic [AW-1:0] address,
  output logic [DW-1:0] writedata,
  output logic          done
);

  localparam int            CW   = cnt_w(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  logic          active;
  logic          restart;
  logic [CW-1:0] addr;
  logic          accept;

  assign accept    = active & ~waitrequest;
  assign done      = accept & (addr == LAST) & ~restart & ~start;
  assign write     = active;
  assign address   = AW'(addr);
  assign writedata = FILL;

  // A restart requested while a write is stalled is parked until that write is accepted,
  // so the address presented to the slave never changes under waitrequest.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      restart <= 1'b0;
      addr    <= '0;
    end else if (!active) begin
      if (start) begin
        active  <= 1'b1;
        restart <= 1'b0;
        addr    <= '0;
      end
    end else if (accept) begin
      if (restart || start) begin
        addr    <= '0;
        restart <= 1'b0;
      end else if (addr == LAST) begin
        addr   <= '0;
        active <= 1'b0;
      end else begin
        addr <= addr + 1'b1;
      end
    end else if (start) begin
      restart <= 1'b1;
    end
  end

endmodule

// File: rtl/ca_run_ctrl.sv
// Sequencer and VRAM arbiter: clear frame, run CA core, dwell, optionally advance rule.
module ca_run_ctrl
  import ca_ctrl_pkg::*;
#(
  parameter int                AVN_AW      = 19,
  parameter int                AVN_DW      = AVN_DW_DEF,
  parameter int                H_DISPLAY   = H_DISPLAY_DEF,
  parameter int                V_DISPLAY   = V_DISPLAY_DEF,
  parameter int                RUN_WRITES  = H_DISPLAY * V_DISPLAY - 1,
  parameter int                HOLD_CYCLES = 50_000_000,
  parameter logic [7:0]        RULE_INIT   = RULE_INIT_DEF,
  parameter logic [AVN_DW-1:0] CLEAR_DATA  = {AVN_DW{1'b1}}
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic              auto_en,
  input  logic              rule_load,
  input  logic [7:0]        rule_in,
  output logic [7:0]        ca_rule,
  output logic              core_rst,
  input  logic              core_avn_write,
  input  logic [AVN_AW-1:0] core_avn_address,
  input  logic [AVN_DW-1:0] core_avn_writedata,
  output logic              core_avn_waitrequest,
  output logic              vram_avn_write,
  output logic [AVN_AW-1:0] vram_avn_address,
  output logic [AVN_DW-1:0] vram_avn_writedata,
  input  logic              vram_avn_waitrequest,
  output logic              busy,
  output logic              gen_done
);

  localparam int            RW        = cnt_w(RUN_WRITES);
  localparam int            HW        = cnt_w(HOLD_CYCLES);
  localparam logic [RW-1:0] RUN_LAST  = RW'(RUN_WRITES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  state_t          state;
  logic [RW-1:0]   run_cnt;
  logic [HW-1:0]   hold_cnt;
  logic [7:0]      rule_pend;
  logic            load_flag;
  logic            start_pend;

  logic              clr_start;
  logic              clr_write;
  logic [AVN_AW-1:0] clr_address;
  logic [AVN_DW-1:0] clr_writedata;
  logic              clr_done;

  logic run_acc, run_last, stall, req, hold_exp, go_clear, advance;

  ca_vram_clear #(
    .AW    (AVN_AW),
    .DW    (AVN_DW),
    .DEPTH (H_DISPLAY * V_DISPLAY),
    .FILL  (CLEAR_DATA)
  ) u_clear (
    .clk         (sys_clk),
    .rst         (sys_rst),
    .start       (clr_start),
    .waitrequest (vram_avn_waitrequest),
    .write       (clr_write),
    .address     (clr_address),
    .writedata   (clr_writedata),
    .done        (clr_done)
  );

  // VRAM belongs to the core only while running; otherwise the fill engine drives it.
  always_comb begin
    if (state == RUN) begin
      vram_avn_write       = core_avn_write;
      vram_avn_address     = core_avn_address;
      vram_avn_writedata   = core_avn_writedata;
      core_avn_waitrequest = vram_avn_waitrequest;
    end else begin
      vram_avn_write       = clr_write;
      vram_avn_address     = clr_address;
      vram_avn_writedata   = clr_writedata;
      core_avn_waitrequest = 1'b1;
    end
  end

  always_comb begin
    run_acc  = (state == RUN) & core_avn_write & ~vram_avn_waitrequest;
    run_last = run_acc & (run_cnt == RUN_LAST);
    stall    = vram_avn_write & vram_avn_waitrequest;
    req      = start | start_pend;
    hold_exp = (hold_cnt == HOLD_LAST);
    go_clear = 1'b0;
    advance  = 1'b0;
    case (state)
      IDLE:    go_clear = start;
      RUN:     go_clear = req & ~run_last & ~stall;
      HOLD: begin
        go_clear = req | (hold_exp & auto_en);
        advance  = ~req & hold_exp & auto_en;
      end
      default: go_clear = 1'b0;
    endcase
    clr_start = go_clear | ((state == CLEAR) & start);
  end

  assign busy = (state != IDLE);

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state      <= IDLE;
      ca_rule    <= RULE_INIT;
      core_rst   <= 1'b1;
      gen_done   <= 1'b0;
      run_cnt    <= '0;
      hold_cnt   <= '0;
      rule_pend  <= 8'd0;
      load_flag  <= 1'b0;
      start_pend <= 1'b0;
    end else begin
      gen_done <= 1'b0;

      // A load coinciding with CLEAR entry stays pending for the following entry.
      if (go_clear) begin
        ca_rule <= load_flag ? rule_pend : (advance ? ca_rule + 8'd1 : ca_rule);
        if (!rule_load) load_flag <= 1'b0;
      end
      if (rule_load) begin
        rule_pend <= rule_in;
        load_flag <= 1'b1;
      end

      if (go_clear)                      start_pend <= 1'b0;
      else if ((state == RUN) && start)  start_pend <= 1'b1;

      case (state)
        IDLE: begin
          core_rst <= 1'b1;
          if (go_clear) state <= CLEAR;
        end
        CLEAR: begin
          core_rst <= 1'b1;
          if (clr_done) begin
            state    <= RUN;
            core_rst <= 1'b0;
          end
        end
        RUN: begin
          if (run_last) begin
            state    <= HOLD;
            gen_done <= 1'b1;
            core_rst <= 1'b1;
            run_cnt  <= '0;
          end else if (go_clear) begin
            state    <= CLEAR;
            core_rst <= 1'b1;
            run_cnt  <= '0;
          end else if (run_acc) begin
            run_cnt <= run_cnt + 1'b1;
          end
        end
        HOLD: begin
          core_rst <= 1'b1;
          if (go_clear) begin
            state    <= CLEAR;
            hold_cnt <= '0;
          end else if (hold_exp) begin
            state    <= IDLE;
            hold_cnt <= '0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ca_run_ctrl.sv
// Directed bench for ca_run_ctrl on an 8x4 frame with a 10-cycle dwell.
module tb_ca_run_ctrl;

  logic        clk;
  logic        sys_rst;
  logic        start;
  logic        auto_en;
  logic        rule_load;
  logic [7:0]  rule_in;
  logic [7:0]  ca_rule;
  logic        core_rst;
  logic        core_avn_write;
  logic [18:0] core_avn_address;
  logic [15:0] core_avn_writedata;
  logic        core_avn_waitrequest;
  logic        vram_avn_write;
  logic [18:0] vram_avn_address;
  logic [15:0] vram_avn_writedata;
  logic        vram_avn_waitrequest;
  logic        busy;
  logic        gen_done;

  int n_cmp = 0;
  int n_err = 0;

  ca_run_ctrl #(
    .H_DISPLAY   (8),
    .V_DISPLAY   (4),
    .RUN_WRITES  (31),
    .HOLD_CYCLES (10)
  ) dut (
    .sys_clk              (clk),
    .sys_rst              (sys_rst),
    .start                (start),
    .auto_en              (auto_en),
    .rule_load            (rule_load),
    .rule_in              (rule_in),
    .ca_rule              (ca_rule),
    .core_rst             (core_rst),
    .core_avn_write       (core_avn_write),
    .core_avn_address     (core_avn_address),
    .core_avn_writedata   (core_avn_writedata),
    .core_avn_waitrequest (core_avn_waitrequest),
    .vram_avn_write       (vram_avn_write),
    .vram_avn_address     (vram_avn_address),
    .vram_avn_writedata   (vram_avn_writedata),
    .vram_avn_waitrequest (vram_avn_waitrequest),
    .busy                 (busy),
    .gen_done             (gen_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 32 fill words expected at addresses 0..31 in order under random waitrequest.
  task automatic run_clear(input logic [7:0] er);
    int acc = 0;
    int cyc = 0;
    while (acc < 32 && cyc < 400) begin
      @(negedge clk);
      start = 1'b0; rule_load = 1'b0;
      core_avn_write = 1'b1; core_avn_address = 19'h5; core_avn_writedata = 16'h1234;
      vram_avn_waitrequest = 1'($urandom_range(0, 1));
      #1;
      chk("clr_write", 32'(vram_avn_write), 32'd1);
      chk("clr_addr", 32'(vram_avn_address), 32'(acc));
      chk("clr_data", 32'(vram_avn_writedata), 32'hFFFF);
      chk("clr_core_wait", 32'(core_avn_waitrequest), 32'd1);
      chk("clr_core_rst", 32'(core_rst), 32'd1);
      chk("clr_rule", 32'(ca_rule), 32'(er));
      if (!vram_avn_waitrequest) acc++;
      cyc++;
    end
    chk("clr_count", 32'(acc), 32'd32);
  endtask

  task automatic run_core(input int n, input logic [7:0] er, input int load_at);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      start = 1'b0; vram_avn_waitrequest = 1'b0;
      rule_load = (k == load_at); rule_in = 8'd90;
      core_avn_write = 1'b1;
      core_avn_address = 19'(k);
      core_avn_writedata = k[0] ? 16'hFFFF : 16'h0000;
      #1;
      chk("run_write", 32'(vram_avn_write), 32'd1);
      chk("run_addr", 32'(vram_avn_address), 32'(k));
      chk("run_data", 32'(vram_avn_writedata), k[0] ? 32'hFFFF : 32'h0);
      chk("run_core_wait", 32'(core_avn_waitrequest), 32'd0);
      chk("run_core_rst", 32'(core_rst), 32'd0);
      chk("run_gen_done", 32'(gen_done), 32'd0);
      chk("run_rule", 32'(ca_rule), 32'(er));
    end
    rule_load = 1'b0;
  endtask

  task automatic hold_phase(input logic [7:0] er);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      core_avn_write = (c == 3); rule_load = 1'b0; vram_avn_waitrequest = 1'b0;
      #1;
      chk("hold_gen_done", 32'(gen_done), 32'(c == 0));
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_core_rst", 32'(core_rst), 32'd1);
      chk("hold_write", 32'(vram_avn_write), 32'd0);
      chk("hold_core_wait", 32'(core_avn_waitrequest), 32'd1);
      chk("hold_rule", 32'(ca_rule), 32'(er));
    end
    core_avn_write = 1'b0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_write"}, 32'(vram_avn_write), 32'd0);
    chk({tag, "_core_rst"}, 32'(core_rst), 32'd1);
    chk({tag, "_core_wait"}, 32'(core_avn_waitrequest), 32'd1);
  endtask

  initial begin
    sys_rst = 1'b1; start = 1'b0; auto_en = 1'b0; rule_load = 1'b0; rule_in = 8'd0;
    core_avn_write = 1'b0; core_avn_address = '0; core_avn_writedata = '0;
    vram_avn_waitrequest = 1'b0;
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;

    // Reset state and idle, with a stray core write that must be ignored.
    repeat (19) @(negedge clk);
    @(negedge clk);
    core_avn_write = 1'b1; core_avn_address = 19'd7; core_avn_writedata = 16'h00AA;
    #1;
    chk("rst_rule", 32'(ca_rule), 32'd30);
    chk("rst_gen_done", 32'(gen_done), 32'd0);
    chk_idle("rst");

    // First generation at rule 30, manual mode.
    @(negedge clk);
    start = 1'b1; core_avn_write = 1'b0;
    run_clear(8'd30);
    run_core(31, 8'd30, -1);
    hold_phase(8'd30);
    @(negedge clk);
    #1;
    chk_idle("gen1_end");
    rule_load = 1'b1; rule_in = 8'd255;

    // Auto mode from rule 255 wraps to 0.
    @(negedge clk);
    rule_load = 1'b0; start = 1'b1; auto_en = 1'b1;
    run_clear(8'd255);
    run_core(31, 8'd255, -1);
    hold_phase(8'd255);
    run_clear(8'd0);

    // Load of 90 mid-run takes effect only at the next CLEAR entry, beating the auto advance.
    run_core(31, 8'd0, 10);
    hold_phase(8'd0);
    run_clear(8'd90);

    // Abort while a core write is stalled.
    auto_en = 1'b0;
    run_core(5, 8'd90, -1);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      start = (c == 0); vram_avn_waitrequest = (c < 5);
      core_avn_write = 1'b1; core_avn_address = 19'd5; core_avn_writedata = 16'hFFFF;
      #1;
      chk("stall_write", 32'(vram_avn_write), 32'd1);
      chk("stall_addr", 32'(vram_avn_address), 32'd5);
      chk("stall_data", 32'(vram_avn_writedata), 32'hFFFF);
      chk("stall_core_wait", 32'(core_avn_waitrequest), 32'(c < 5));
      chk("stall_core_rst", 32'(core_rst), 32'd0);
    end
    @(negedge clk);
    start = 1'b0; core_avn_write = 1'b0; vram_avn_waitrequest = 1'b1;
    #1;
    chk("abort_write", 32'(vram_avn_write), 32'd1);
    chk("abort_addr", 32'(vram_avn_address), 32'd0);
    chk("abort_data", 32'(vram_avn_writedata), 32'hFFFF);
    chk("abort_core_rst", 32'(core_rst), 32'd1);
    chk("abort_rule", 32'(ca_rule), 32'd90);
    chk("abort_busy", 32'(busy), 32'd1);
    run_clear(8'd90);
    run_core(31, 8'd90, -1);
    hold_phase(8'd90);
    @(negedge clk);
    #1;
    chk_idle("gen4_end");

    // Asynchronous reset in the middle of a clear.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_rule", 32'(ca_rule), 32'd30);
    chk("arst_gen_done", 32'(gen_done), 32'd0);
    chk_idle("arst");
    @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);
    #1;
    chk_idle("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
